spi_mem_bridge: RTL and testbench

SPI_MEM_BRIDGE -- requirements
Module: spi_mem_bridge

---
 rtl/spi_mem_bridge.sv | 276 +++++++++++++++++++++++++++
 tb/tb_spi_mem_bridge.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_bridge.sv
// spi_mem_bridge
//
// SPI (mode 0, MSB first) slave that turns byte commands from an SPI master
// into single-word memory requests on the i_clk domain.
//
// Command set (first byte of a command, decoded in IDLE):
//   0x01 + ADDR_W/8 bytes : load the address register
//   0x02 + DATA_W/8 bytes : load write data and issue a memory write
//   0x03 + DATA_W/8 dummy : memory read, word returned on miso
//                           (only when SPI_BRIDGE_READ_EN is defined)
//
// Build option:
//   SPI_BRIDGE_READ_EN - compiles in opcode 0x03, the READ/SEND path and the
//                        read-data capture register. Without it 0x03 is an
//                        illegal opcode, o_mem_we is tied to 1, miso to 0.
//
// Ports:
//   i_clk, i_spi_rst_n     : clock, asynchronous active-low reset
//   sclk, cs, mosi, miso   : SPI slave pins (sclk/cs/mosi async to i_clk)
//   o_mem_valid, o_mem_we  : memory request strobe and direction
//   o_mem_addr, o_mem_wdata: request address and write data
//   i_mem_ready            : request accepted (i_mem_rdata valid same cycle)
//   i_mem_rdata            : read data
//   o_busy                 : FSM not in IDLE
//   o_err                  : sticky protocol error
module spi_mem_bridge #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int AUTO_INC = 1
) (
  input  logic              i_clk,
  input  logic              i_spi_rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              o_mem_valid,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_err
);

  localparam int              ADDR_BYTES = ADDR_W / 8;
  localparam int              DATA_BYTES = DATA_W / 8;
  localparam logic [7:0]      ADDR_LAST  = 8'(ADDR_BYTES - 1);
  localparam logic [7:0]      DATA_LAST  = 8'(DATA_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = (AUTO_INC != 0) ? ADDR_W'(DATA_BYTES) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    READ  = 3'd4,
    SEND  = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sclkSync_q;
  logic [1:0]          csSync_q;
  logic [1:0]          mosiSync_q;
  logic [2:0]          bitCnt_q, bitCnt_d;
  logic [6:0]          shift_q, shift_d;
  logic [7:0]          byteCnt_q, byteCnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                err_q, err_d;

  logic                sclkRise;
  logic                csHigh;
  logic                mosiBit;
  logic                byteDone;
  logic [7:0]          rxByte;
  logic                opLegal;

`ifdef SPI_BRIDGE_READ_EN
  logic [DATA_W-1:0]   txShift_q, txShift_d;
  logic                txPend_q, txPend_d;
  logic                sclkFall;
`else
  logic                unusedRdata;
  assign unusedRdata = ^i_mem_rdata;
`endif

  // Two-flop synchronisers; sclkSync_q[2] is the previous synchronised sclk
  // and is only used for edge detection.
  always_ff @(posedge i_clk or negedge i_spi_rst_n) begin
    if (!i_spi_rst_n) begin
      sclkSync_q <= '0;
      csSync_q   <= '0;
      mosiSync_q <= '0;
    end else begin
      sclkSync_q <= {sclkSync_q[1:0], sclk};
      csSync_q   <= {csSync_q[0], cs};
      mosiSync_q <= {mosiSync_q[0], mosi};
    end
  end

  assign sclkRise = sclkSync_q[1] & ~sclkSync_q[2];
  assign csHigh   = csSync_q[1];
  assign mosiBit  = mosiSync_q[1];
  assign rxByte   = {shift_q, mosiBit};

`ifdef SPI_BRIDGE_READ_EN
  assign sclkFall = ~sclkSync_q[1] & sclkSync_q[2];
`endif

  // Byte assembly. Deasserting cs throws away a partial byte but leaves the
  // FSM alone, so a master may frame every byte separately.
  always_comb begin
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    byteDone = 1'b0;
    if (csHigh) begin
      bitCnt_d = '0;
      shift_d  = '0;
    end else if (sclkRise) begin
      bitCnt_d = bitCnt_q + 3'd1;
      shift_d  = {shift_q[5:0], mosiBit};
      byteDone = (bitCnt_q == 3'd7);
    end
  end

  always_comb begin
    opLegal = (rxByte == 8'h01) || (rxByte == 8'h02);
`ifdef SPI_BRIDGE_READ_EN
    if (rxByte == 8'h03) opLegal = 1'b1;
`endif
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_spi_rst_n) begin
    if (!i_spi_rst_n) state_q <= IDLE;
    else              state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (byteDone) begin
          case (rxByte)
            8'h01:   state_d = ADDR;
            8'h02:   state_d = DATA;
`ifdef SPI_BRIDGE_READ_EN
            8'h03:   state_d = READ;
`endif
            default: state_d = IDLE;
          endcase
        end
      end
      ADDR:  if (byteDone && byteCnt_q == ADDR_LAST) state_d = IDLE;
      DATA:  if (byteDone && byteCnt_q == DATA_LAST) state_d = WRITE;
      WRITE: if (i_mem_ready) state_d = IDLE;
`ifdef SPI_BRIDGE_READ_EN
      READ:  if (i_mem_ready) state_d = SEND;
      SEND:  if (byteDone && byteCnt_q == DATA_LAST) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy      = (state_q != IDLE);
    o_mem_valid = (state_q == WRITE);
    miso        = 1'b0;
`ifdef SPI_BRIDGE_READ_EN
    if (state_q == READ) o_mem_valid = 1'b1;
    o_mem_we = (state_q == WRITE);
    // Raw cs gates miso so the line is released as soon as the master
    // deselects us, without waiting for the synchroniser.
    if (state_q == SEND && !cs) miso = txShift_q[DATA_W-1];
`else
    o_mem_we = 1'b1;
`endif
  end

  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_err       = err_q;

  // Datapath next-state. A byte that completes while a memory request is
  // still outstanding is dropped and flagged, never allowed to disturb the
  // request fields.
  always_comb begin
    byteCnt_d = byteCnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    err_d     = err_q;
`ifdef SPI_BRIDGE_READ_EN
    txShift_d = txShift_q;
    txPend_d  = txPend_q;
`endif
    case (state_q)
      IDLE: begin
        byteCnt_d = '0;
        if (byteDone && !opLegal) err_d = 1'b1;
      end
      ADDR: begin
        if (byteDone) begin
          addr_d    = (addr_q << 8) | ADDR_W'(rxByte);
          byteCnt_d = byteCnt_q + 8'd1;
        end
      end
      DATA: begin
        if (byteDone) begin
          wdata_d   = (wdata_q << 8) | DATA_W'(rxByte);
          byteCnt_d = byteCnt_q + 8'd1;
        end
      end
      WRITE: begin
        if (byteDone)    err_d  = 1'b1;
        if (i_mem_ready) addr_d = addr_q + ADDR_STEP;
      end
`ifdef SPI_BRIDGE_READ_EN
      READ: begin
        if (byteDone) err_d = 1'b1;
        if (i_mem_ready) begin
          txShift_d = i_mem_rdata;
          txPend_d  = 1'b0;
        end
      end
      SEND: begin
        // Shift only on a falling edge that follows a rising edge seen in
        // SEND; the falling edge that closes the opcode byte must not
        // consume the MSB.
        if (!csHigh && sclkRise) begin
          txPend_d = 1'b1;
        end else if (!csHigh && sclkFall && txPend_q) begin
          txShift_d = txShift_q << 1;
          txPend_d  = 1'b0;
        end
        if (byteDone) begin
          byteCnt_d = byteCnt_q + 8'd1;
          if (byteCnt_q == DATA_LAST) addr_d = addr_q + ADDR_STEP;
        end
      end
`endif
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_spi_rst_n) begin
    if (!i_spi_rst_n) begin
      bitCnt_q  <= '0;
      shift_q   <= '0;
      byteCnt_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef SPI_BRIDGE_READ_EN
      txShift_q <= '0;
      txPend_q  <= 1'b0;
`endif
    end else begin
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      byteCnt_q <= byteCnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      err_q     <= err_d;
`ifdef SPI_BRIDGE_READ_EN
      txShift_q <= txShift_d;
      txPend_q  <= txPend_d;
`endif
    end
  end

endmodule

// File: tb/tb_spi_mem_bridge.sv
// tb_spi_mem_bridge
//
// Drives spi_mem_bridge as an SPI mode-0 master with randomized addresses,
// data and memory stall lengths, and compares every memory request and the
// visible register state against a transaction-level reference model.
// Build option SPI_BRIDGE_READ_EN enables the read-path scenarios.
module tb_spi_mem_bridge;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int HALF        = 40;
  localparam int BURST_WORDS = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } memTxn_t;

  logic              i_clk;
  logic              i_spi_rst_n;
  logic              sclk;
  logic              cs;
  logic              mosi;
  logic              miso;
  logic              o_mem_valid;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic              i_mem_ready;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              o_busy;
  logic              o_err;

  int testsRun    = 0;
  int testsFailed = 0;

  memTxn_t     obsQ[$];
  memTxn_t     expQ[$];
  logic [31:0] addrModel;
  logic [31:0] dataModel;
  logic        weAfterReset;

  spi_mem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .AUTO_INC(1)) dut (
    .i_clk       (i_clk),
    .i_spi_rst_n (i_spi_rst_n),
    .sclk        (sclk),
    .cs          (cs),
    .mosi        (mosi),
    .miso        (miso),
    .o_mem_valid (o_mem_valid),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ready (i_mem_ready),
    .i_mem_rdata (i_mem_rdata),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Record every accepted memory request
  always @(posedge i_clk) begin
    if (i_spi_rst_n && o_mem_valid && i_mem_ready)
      obsQ.push_back({o_mem_we, o_mem_addr, o_mem_wdata});
  end

  // Hard time limit so the run always ends
  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: time limit reached, observed running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One SPI byte, mode 0: miso sampled just before each rising edge
  task automatic applyStimulus(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      #HALF;
      rx[i] = miso;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic partialBits(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = 1'($urandom);
      #HALF;
      sclk = 1'b1;
      #HALF;
      sclk = 1'b0;
    end
  endtask

  task automatic csLow();
    @(negedge i_clk);
    cs = 1'b0;
    #HALF;
  endtask

  task automatic csHigh();
    #HALF;
    cs = 1'b1;
    #(2 * HALF);
  endtask

  task automatic sendWord(input logic [31:0] w, output logic [31:0] rxWord);
    logic [7:0] rx;
    for (int b = 3; b >= 0; b--) begin
      applyStimulus(w[b*8 +: 8], rx);
      rxWord[b*8 +: 8] = rx;
    end
  endtask

  task automatic cmdSetAddr(input logic [31:0] a);
    logic [7:0]  rx;
    logic [31:0] rxWord;
    csLow();
    applyStimulus(8'h01, rx);
    sendWord(a, rxWord);
    csHigh();
    addrModel = a;
    checkOutput("misoIdle", {64'd0, rx} | {40'd0, rxWord}, 72'd0);
  endtask

  task automatic sendWriteBytes(input logic [31:0] d);
    logic [7:0]  rx;
    logic [31:0] rxWord;
    applyStimulus(8'h02, rx);
    sendWord(d, rxWord);
  endtask

  task automatic modelWrite(input logic [31:0] d);
    expQ.push_back({1'b1, addrModel, d});
    addrModel = addrModel + 32'd4;
    dataModel = d;
  endtask

  task automatic cmdWrite(input logic [31:0] d);
    csLow();
    sendWriteBytes(d);
    csHigh();
    modelWrite(d);
  endtask

  task automatic waitValid(input int maxCycles, input string tag);
    int n = 0;
    while (!o_mem_valid && n < maxCycles) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput(tag, {71'd0, o_mem_valid}, 72'd1);
  endtask

  task automatic waitIdle(input int maxCycles, input string tag);
    int n = 0;
    while (o_busy && n < maxCycles) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput(tag, {71'd0, o_busy}, 72'd0);
  endtask

  task automatic checkWrites(input string tag);
    checkOutput({tag, "Count"}, 72'(obsQ.size()), 72'(expQ.size()));
    while (obsQ.size() > 0 && expQ.size() > 0)
      checkOutput({tag, "Txn"}, 72'(obsQ.pop_front()), 72'(expQ.pop_front()));
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "Valid"}, {71'd0, o_mem_valid}, 72'd0);
    checkOutput({tag, "We"},    {71'd0, o_mem_we},    {71'd0, weAfterReset});
    checkOutput({tag, "Busy"},  {71'd0, o_busy},      72'd0);
    checkOutput({tag, "Err"},   {71'd0, o_err},       72'd0);
    checkOutput({tag, "Miso"},  {71'd0, miso},        72'd0);
    checkOutput({tag, "Addr"},  72'(o_mem_addr),      72'd0);
    checkOutput({tag, "Wdata"}, 72'(o_mem_wdata),     72'd0);
  endtask

  task automatic resetPulse(input bit doCheck, input string tag);
    @(negedge i_clk);
    #2;
    i_spi_rst_n = 1'b0;
    #1;
    if (doCheck) checkResetState(tag);
    #20;
    @(negedge i_clk);
    i_spi_rst_n = 1'b1;
    addrModel = '0;
    dataModel = '0;
    obsQ.delete();
    expQ.delete();
    repeat (3) @(negedge i_clk);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rxWord;
    logic [7:0]  rx;
    logic        stableOk;
    int          stall;

`ifdef SPI_BRIDGE_READ_EN
    weAfterReset = 1'b0;
`else
    weAfterReset = 1'b1;
`endif
    i_spi_rst_n = 1'b1;
    sclk        = 1'b0;
    cs          = 1'b1;
    mosi        = 1'b0;
    i_mem_ready = 1'b1;
    i_mem_rdata = '0;
    addrModel   = '0;
    dataModel   = '0;

    // Power-on reset
    #3 i_spi_rst_n = 1'b0;
    #1 checkResetState("por");
    #30;
    @(negedge i_clk);
    i_spi_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);

    // Single write with memory always ready
    cmdSetAddr(32'h4000_0000);
    cmdWrite(32'hDEAD_BEEF);
    checkWrites("write1");
    checkOutput("write1AddrInc", 72'(o_mem_addr), 72'(addrModel));
    checkOutput("write1Err", {71'd0, o_err}, 72'd0);

    // Address wrap on increment
    cmdSetAddr(32'hFFFF_FFFC);
    cmdWrite($urandom);
    checkWrites("wrap");
    checkOutput("wrapAddr", 72'(o_mem_addr), 72'd0);

    // A partial byte cut short by cs is discarded
    csLow();
    partialBits(5);
    csHigh();
    a = $urandom;
    cmdSetAddr(a);
    checkOutput("partialAddr", 72'(o_mem_addr), 72'(a));
    checkOutput("partialErr", {71'd0, o_err}, 72'd0);
    checkOutput("partialBusy", {71'd0, o_busy}, 72'd0);

    // Randomized writes with random memory stalls
    for (int k = 0; k < 6; k++) begin
      if ($urandom_range(0, 1) == 1) cmdSetAddr($urandom);
      d     = $urandom;
      stall = $urandom_range(0, 12);
      i_mem_ready = 1'b0;
      cmdWrite(d);
      waitValid(50, "rndValid");
      repeat (stall) @(negedge i_clk);
      i_mem_ready = 1'b1;
      waitIdle(20, "rndIdle");
    end
    checkWrites("rnd");
    checkOutput("rndAddr", 72'(o_mem_addr), 72'(addrModel));

    // Back-to-back write burst in one cs frame
    cmdSetAddr(32'h2000_0000);
    csLow();
    for (int w = 0; w < BURST_WORDS; w++) begin
      d = $urandom;
      sendWriteBytes(d);
      modelWrite(d);
    end
    csHigh();
    checkWrites("burst");
    checkOutput("burstAddr", 72'(o_mem_addr), 72'(32'h2000_0000 + BURST_WORDS * 4));
    checkOutput("burstErr", {71'd0, o_err}, 72'd0);

    // Long memory stall: request held stable, stray byte flagged
    a = $urandom;
    d = $urandom;
    cmdSetAddr(a);
    i_mem_ready = 1'b0;
    cmdWrite(d);
    waitValid(50, "stallValid");
    stableOk = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (!(o_mem_valid && o_mem_we && o_busy && o_mem_addr == a && o_mem_wdata == d))
        stableOk = 1'b0;
    end
    checkOutput("stallStable", {71'd0, stableOk}, 72'd1);
    checkOutput("stallErrBefore", {71'd0, o_err}, 72'd0);
    csLow();
    applyStimulus(8'hA5, rx);
    csHigh();
    checkOutput("stallErr", {71'd0, o_err}, 72'd1);
    checkOutput("stallReq", {7'd0, o_mem_valid, o_mem_addr, o_mem_wdata}, {7'd0, 1'b1, a, d});
    i_mem_ready = 1'b1;
    waitIdle(20, "stallIdle");
    checkWrites("stall");
    checkOutput("stallAddr", 72'(o_mem_addr), 72'(a + 32'd4));

    resetPulse(1'b1, "midRst");

`ifdef SPI_BRIDGE_READ_EN
    // Read back a word on miso
    cmdSetAddr(32'h4000_0000);
    i_mem_rdata = 32'h1234_5678;
    csLow();
    applyStimulus(8'h03, rx);
    sendWord($urandom, rxWord);
    csHigh();
    expQ.push_back({1'b0, 32'h4000_0000, dataModel});
    addrModel = addrModel + 32'd4;
    checkOutput("readMiso", 72'(rxWord), 72'(32'h1234_5678));
    checkOutput("readAddr", 72'(o_mem_addr), 72'(addrModel));
    checkWrites("read");
    // Randomized read with per-byte cs framing and a stalled memory
    d = $urandom;
    i_mem_rdata = d;
    i_mem_ready = 1'b0;
    csLow();
    applyStimulus(8'h03, rx);
    csHigh();
    repeat ($urandom_range(1, 10)) @(negedge i_clk);
    i_mem_ready = 1'b1;
    rxWord = '0;
    for (int b = 3; b >= 0; b--) begin
      csLow();
      applyStimulus(8'($urandom), rx);
      csHigh();
      rxWord[b*8 +: 8] = rx;
    end
    expQ.push_back({1'b0, addrModel, dataModel});
    addrModel = addrModel + 32'd4;
    checkOutput("readRndMiso", 72'(rxWord), 72'(d));
    checkOutput("readRndAddr", 72'(o_mem_addr), 72'(addrModel));
    checkOutput("readRndErr", {71'd0, o_err}, 72'd0);
    checkWrites("readRnd");
`else
    // Without the read path 0x03 is an illegal opcode
    csLow();
    applyStimulus(8'h03, rx);
    csHigh();
    checkOutput("op03Err", {71'd0, o_err}, 72'd1);
    checkOutput("op03Busy", {71'd0, o_busy}, 72'd0);
    checkOutput("op03Miso", {64'd0, rx}, 72'd0);
    checkWrites("op03");
`endif

    resetPulse(1'b0, "");

    // Illegal opcode
    csLow();
    applyStimulus(8'h55, rx);
    csHigh();
    checkOutput("illegalErr", {71'd0, o_err}, 72'd1);
    checkOutput("illegalBusy", {71'd0, o_busy}, 72'd0);

    resetPulse(1'b0, "");

    // Partial byte then reset during a stalled write
    a = $urandom;
    d = $urandom;
    cmdSetAddr(a);
    i_mem_ready = 1'b0;
    csLow();
    sendWriteBytes(d);
    csHigh();
    waitValid(50, "rstWrValid");
    csLow();
    partialBits(5);
    csHigh();
    checkOutput("rstWrErr", {71'd0, o_err}, 72'd0);
    checkOutput("rstWrReq", {7'd0, o_mem_valid, o_mem_addr, o_mem_wdata}, {7'd0, 1'b1, a, d});
    resetPulse(1'b1, "rstWr");
    i_mem_ready = 1'b1;
    repeat (5) @(negedge i_clk);
    checkWrites("rstWrAbandon");
    d = $urandom;
    cmdSetAddr(32'h0000_1000);
    cmdWrite(d);
    checkWrites("postRst");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
